// File: rtl/mvm_stream_p_if.sv
// Operand and result valid/ready streams of the matrix-vector multiplier.
// slave is the multiplier side, master is the host/consumer side.
interface mvm_stream_p_if #(
  parameter int unsigned B  = 16,
  parameter int unsigned OW = 35
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [B-1:0]  data_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] data_out;

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out
  );
endinterface

// File: rtl/mvm_stream_p.sv
// Streaming y = A*x multiplier, M x N signed matrix, P MAC lanes (lane l owns rows l, l+P, ...).
// Define MVM_PIPE_MAC_EN to register products ahead of the accumulators (CALC one cycle longer).
module mvm_stream_p #(
  parameter int unsigned M  = 8,
  parameter int unsigned N  = 8,
  parameter int unsigned P  = 1,
  parameter int unsigned B  = 16,
  parameter int unsigned OW = 2 * B + $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          loadMatrix,
  input  logic          loadVector,
  input  logic          start,
  mvm_stream_p_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned MN = M * N;
  localparam int unsigned G  = M / P;
  localparam int unsigned AW = $clog2(MN);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned TOTAL = G * N;
`ifdef MVM_PIPE_MAC_EN
  localparam int unsigned CALC_LEN = TOTAL + 1;
`else
  localparam int unsigned CALC_LEN = TOTAL;
`endif
  localparam int unsigned KW = $clog2(CALC_LEN + 1);

  typedef enum logic [2:0] {StIdle, StLoadM, StLoadV, StCalc, StDrain} state_e;

  state_e state_q, state_d;

  logic signed [B-1:0]  a_mem [MN];
  logic signed [B-1:0]  x_mem [N];
  logic signed [OW-1:0] y_mem [M];

  logic          a_ok_q, x_ok_q;
  logic [AW-1:0] ld_addr_q;
  logic [GW-1:0] grp_q;
  logic [CW-1:0] col_q;
  logic [KW-1:0] cyc_q;
  logic [RW-1:0] rd_q;
  logic          done_q, err_q;

  logic wr_en, ld_last, cmd_load, issue, calc_last, out_fire, rd_last, start_bad;

  // Per-lane datapath: stage 1 multiply, stage 2 accumulate.
  logic [AW-1:0]         a_idx    [P];
  logic signed [2*B-1:0] prod     [P];
  logic signed [2*B-1:0] mac_prod [P];
  logic signed [OW-1:0]  acc_q    [P];
  logic signed [OW-1:0]  acc_d    [P];
  logic [RW-1:0]         wb_row   [P];
  logic                  wb       [P];
  logic [CW-1:0]         mac_col;
  logic [GW-1:0]         mac_grp;
  logic                  mac_v;

  assign wr_en     = (state_q == StLoadM || state_q == StLoadV) && bus.in_valid;
  assign ld_last   = (state_q == StLoadM) ? (ld_addr_q == AW'(MN - 1))
                                          : (ld_addr_q == AW'(N - 1));
  assign cmd_load  = (state_q == StIdle) && !start && (loadVector || loadMatrix);
  assign start_bad = (state_q == StIdle) && start && !(a_ok_q && x_ok_q);
  assign issue     = (state_q == StCalc) && (cyc_q < KW'(TOTAL));
  assign calc_last = (state_q == StCalc) && (cyc_q == KW'(CALC_LEN - 1));
  assign out_fire  = (state_q == StDrain) && bus.out_ready;
  assign rd_last   = (rd_q == RW'(M - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (a_ok_q && x_ok_q) ? StCalc : StIdle;
        end else if (loadVector) begin
          state_d = StLoadV;
        end else if (loadMatrix) begin
          state_d = StLoadM;
        end
      end
      StLoadM, StLoadV: if (wr_en && ld_last) state_d = StIdle;
      StCalc:           if (calc_last) state_d = StDrain;
      StDrain:          if (out_fire && rd_last) state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.data_out  = '0;
    busy          = (state_q != StIdle);
    done          = done_q;
    err           = err_q;
    case (state_q)
      StLoadM, StLoadV: bus.in_ready = 1'b1;
      StDrain: begin
        bus.out_valid = 1'b1;
        bus.data_out  = y_mem[rd_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_ok_q    <= 1'b0;
      x_ok_q    <= 1'b0;
      ld_addr_q <= '0;
      grp_q     <= '0;
      col_q     <= '0;
      cyc_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= out_fire && rd_last;
      err_q  <= start_bad;

      if (cmd_load) begin
        ld_addr_q <= '0;
      end else if (wr_en) begin
        ld_addr_q <= ld_last ? '0 : ld_addr_q + AW'(1);
      end
      if (wr_en && ld_last) begin
        if (state_q == StLoadM) a_ok_q <= 1'b1;
        else                    x_ok_q <= 1'b1;
      end

      if (state_q == StCalc) begin
        if (issue) begin
          if (col_q == CW'(N - 1)) begin
            col_q <= '0;
            grp_q <= (grp_q == GW'(G - 1)) ? '0 : grp_q + GW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        cyc_q <= calc_last ? '0 : cyc_q + KW'(1);
      end else begin
        grp_q <= '0;
        col_q <= '0;
        cyc_q <= '0;
      end

      if (out_fire) begin
        rd_q <= rd_last ? '0 : rd_q + RW'(1);
      end else if (state_q != StDrain) begin
        rd_q <= '0;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < int'(P); l++) begin
      a_idx[l] = AW'((grp_q * P + l) * N + col_q);
      prod[l]  = a_mem[a_idx[l]] * x_mem[col_q];
    end
  end

`ifdef MVM_PIPE_MAC_EN
  logic signed [2*B-1:0] prod_q [P];
  logic [CW-1:0]         pcol_q;
  logic [GW-1:0]         pgrp_q;
  logic                  pv_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_q   <= 1'b0;
      pcol_q <= '0;
      pgrp_q <= '0;
      for (int l = 0; l < int'(P); l++) prod_q[l] <= '0;
    end else begin
      pv_q   <= issue;
      pcol_q <= col_q;
      pgrp_q <= grp_q;
      for (int l = 0; l < int'(P); l++) prod_q[l] <= prod[l];
    end
  end

  assign mac_v    = pv_q;
  assign mac_col  = pcol_q;
  assign mac_grp  = pgrp_q;
  assign mac_prod = prod_q;
`else
  assign mac_v    = issue;
  assign mac_col  = col_q;
  assign mac_grp  = grp_q;
  assign mac_prod = prod;
`endif

  // Products are sign-extended to OW; the accumulator restarts on column 0 of each row group.
  always_comb begin
    for (int l = 0; l < int'(P); l++) begin
      acc_d[l]  = ((mac_col == '0) ? '0 : acc_q[l])
                + {{(OW - 2 * B){mac_prod[l][2*B-1]}}, mac_prod[l]};
      wb[l]     = mac_v && (mac_col == CW'(N - 1));
      wb_row[l] = RW'(mac_grp * P + l);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < int'(P); l++) acc_q[l] <= '0;
    end else if (mac_v) begin
      for (int l = 0; l < int'(P); l++) acc_q[l] <= acc_d[l];
    end
  end

  // Operand and result storage survives reset.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == StLoadM) a_mem[ld_addr_q] <= bus.data_in;
    if (wr_en && state_q == StLoadV) x_mem[ld_addr_q[CW-1:0]] <= bus.data_in;
    for (int l = 0; l < int'(P); l++) begin
      if (wb[l]) y_mem[wb_row[l]] <= acc_d[l];
    end
  end

endmodule

// File: tb/tb_mvm_stream_p.sv
// Directed bench for mvm_stream_p: a P=1 and a P=4 instance receive identical stimulus.
module tb_mvm_stream_p;
  localparam int unsigned B  = 16;
  localparam int unsigned OW = 35;
`ifdef MVM_PIPE_MAC_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0;
  logic busy1, done1, err1, busy4, done4, err4;
  int   n_checks = 0;
  int   n_pass = 0;

  mvm_stream_p_if #(.B(B), .OW(OW)) bus1 ();
  mvm_stream_p_if #(.B(B), .OW(OW)) bus4 ();

  mvm_stream_p #(.M(8), .N(8), .P(1), .B(B)) u_p1 (
    .clk(clk), .reset(reset), .loadMatrix(load_matrix), .loadVector(load_vector),
    .start(start), .bus(bus1.slave), .busy(busy1), .done(done1), .err(err1)
  );

  mvm_stream_p #(.M(8), .N(8), .P(4), .B(B)) u_p4 (
    .clk(clk), .reset(reset), .loadMatrix(load_matrix), .loadVector(load_vector),
    .start(start), .bus(bus4.slave), .busy(busy4), .done(done4), .err(err4)
  );

  always #5 clk = ~clk;

  task automatic load(input bit mat, input logic signed [B-1:0] w [64], input int cnt,
                      input bit gaps, output bit ok);
    int i, guard;
    @(negedge clk);
    load_matrix = mat;
    load_vector = !mat;
    @(negedge clk);
    load_matrix = 1'b0;
    load_vector = 1'b0;
    i = 0;
    guard = 0;
    while (i < cnt && guard < 400) begin
      guard++;
      if (gaps && (guard % 4 == 0)) begin
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
      end else begin
        bus1.in_valid = 1'b1;
        bus4.in_valid = 1'b1;
        bus1.data_in  = w[i];
        bus4.data_in  = w[i];
        if (bus1.in_ready && bus4.in_ready) i++;
      end
      @(negedge clk);
    end
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    ok = (i == cnt);
  endtask

  task automatic run_calc(output int lat1, output int lat4, output bit busy_ok);
    int j;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat1 = -1;
    lat4 = -1;
    busy_ok = busy1 && busy4;
    j = 0;
    while ((lat1 < 0 || lat4 < 0) && j < 300) begin
      if (lat1 < 0 && bus1.out_valid) lat1 = j;
      if (lat4 < 0 && bus4.out_valid) lat4 = j;
      if (lat1 < 0 || lat4 < 0) begin
        @(negedge clk);
        j++;
      end
    end
  endtask

  task automatic drain(input bit sel, input bit [3:0] pat, output logic signed [OW-1:0] y [8],
                       output int n, output int unstable, output bit done_ok);
    int k;
    logic v, r, prev_stall;
    logic signed [OW-1:0] d, prev_d;
    n = 0;
    k = 0;
    unstable = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    for (int q = 0; q < 8; q++) y[q] = '0;
    while (n < 8 && k < 100) begin
      v = sel ? bus4.out_valid : bus1.out_valid;
      d = sel ? bus4.data_out : bus1.data_out;
      if (prev_stall && d !== prev_d) unstable++;
      r = pat[k % 4];
      if (sel) bus4.out_ready = r;
      else     bus1.out_ready = r;
      if (v && r) begin
        y[n] = d;
        n++;
      end
      prev_stall = v && !r;
      prev_d = d;
      k++;
      @(negedge clk);
    end
    bus1.out_ready = 1'b0;
    bus4.out_ready = 1'b0;
    done_ok = (sel ? {done4, bus4.out_valid, busy4} : {done1, bus1.out_valid, busy1}) === 3'b100;
    @(negedge clk);
    done_ok = done_ok && ((sel ? done4 : done1) === 1'b0);
  endtask

  task automatic test_reset();
    bus1.in_valid = 1'b0; bus4.in_valid = 1'b0;
    bus1.data_in = '0;    bus4.data_in = '0;
    bus1.out_ready = 1'b0; bus4.out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy1, done1, err1, bus1.in_ready, bus1.out_valid} !== 5'b0 || bus1.data_out !== '0)
      $display("FAIL reset_p1: flags=%b data=%0d, required 00000/0",
               {busy1, done1, err1, bus1.in_ready, bus1.out_valid}, bus1.data_out);
    else n_pass++;
    n_checks++;
    if ({busy4, done4, err4, bus4.in_ready, bus4.out_valid} !== 5'b0 || bus4.data_out !== '0)
      $display("FAIL reset_p4: flags=%b data=%0d, required 00000/0",
               {busy4, done4, err4, bus4.in_ready, bus4.out_valid}, bus4.data_out);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy1, busy4, bus1.in_ready, bus4.in_ready} !== 4'b0)
      $display("FAIL idle_after_reset: busy/in_ready=%b, required 0000",
               {busy1, busy4, bus1.in_ready, bus4.in_ready});
    else n_pass++;
  endtask

  task automatic test_no_load();
    @(negedge clk);
    bus1.in_valid = 1'b1; bus4.in_valid = 1'b1;
    bus1.data_in = 16'sd5; bus4.data_in = 16'sd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({err1, err4} !== 2'b11)
      $display("FAIL noload_err: err=%b, required 11", {err1, err4});
    else n_pass++;
    n_checks++;
    if ({busy1, busy4, bus1.out_valid, bus4.out_valid, bus1.in_ready, bus4.in_ready} !== 6'b0)
      $display("FAIL noload_idle: busy/out_valid/in_ready=%b, required 000000",
               {busy1, busy4, bus1.out_valid, bus4.out_valid, bus1.in_ready, bus4.in_ready});
    else n_pass++;
    @(negedge clk);
    bus1.in_valid = 1'b0; bus4.in_valid = 1'b0;
    n_checks++;
    if ({err1, err4, busy1, busy4} !== 4'b0)
      $display("FAIL noload_pulse: err/busy=%b, required 0000", {err1, err4, busy1, busy4});
    else n_pass++;
  endtask

  // Starts a computation and drains both instances, comparing against exp.
  task automatic compute_and_check(input string tag, input bit [3:0] pat,
                                   input logic signed [OW-1:0] exp [8]);
    int lat1, lat4, n, unstable;
    bit busy_ok, done_ok;
    logic signed [OW-1:0] y [8];
    run_calc(lat1, lat4, busy_ok);
    n_checks++;
    if (!busy_ok) $display("FAIL %s_busy: busy low during CALC, required 1", tag);
    else n_pass++;
    n_checks++;
    if (lat1 !== 64 + PIPE) $display("FAIL %s_calc_p1: %0d cycles, required %0d", tag, lat1, 64 + PIPE);
    else n_pass++;
    n_checks++;
    if (lat4 !== 16 + PIPE) $display("FAIL %s_calc_p4: %0d cycles, required %0d", tag, lat4, 16 + PIPE);
    else n_pass++;
    for (int s = 0; s < 2; s++) begin
      drain(s[0], pat, y, n, unstable, done_ok);
      n_checks++;
      if (n !== 8) $display("FAIL %s_count_s%0d: %0d results, required 8", tag, s, n);
      else n_pass++;
      for (int q = 0; q < 8; q++) begin
        n_checks++;
        if (y[q] !== exp[q])
          $display("FAIL %s_y_s%0d[%0d]: got %0d, required %0d", tag, s, q, y[q], exp[q]);
        else n_pass++;
      end
      n_checks++;
      if (unstable !== 0) $display("FAIL %s_stable_s%0d: %0d changes while stalled, required 0", tag, s, unstable);
      else n_pass++;
      n_checks++;
      if (!done_ok) $display("FAIL %s_done_s%0d: done pulse wrong, required one cycle after last", tag, s);
      else n_pass++;
    end
  endtask

  task automatic test_identity();
    logic signed [B-1:0] a [64];
    logic signed [B-1:0] x [64];
    logic signed [OW-1:0] exp [8];
    bit ok;
    for (int i = 0; i < 64; i++) begin
      a[i] = (i / 8 == i % 8) ? 16'sd1 : 16'sd0;
      x[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      x[i] = 16'(i + 1);
      exp[i] = 35'(i + 1);
    end
    load(1'b1, a, 64, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL ident_load_a: load stalled, required 64 words accepted");
    else n_pass++;
    load(1'b0, x, 8, 1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL ident_load_x: load stalled, required 8 words accepted");
    else n_pass++;
    compute_and_check("ident", 4'b1111, exp);
  endtask

  task automatic test_stall();
    logic signed [OW-1:0] exp [8];
    for (int i = 0; i < 8; i++) exp[i] = 35'(i + 1);
    compute_and_check("stall", 4'b1001, exp);
  endtask

  task automatic test_reload_x();
    logic signed [B-1:0] x [64];
    logic signed [OW-1:0] exp [8];
    bit ok;
    for (int i = 0; i < 64; i++) x[i] = '0;
    for (int i = 0; i < 8; i++) begin
      x[i] = 16'(2 * (i + 1));
      exp[i] = 35'(2 * (i + 1));
    end
    load(1'b0, x, 8, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL reload_x_load: load stalled, required 8 words accepted");
    else n_pass++;
    compute_and_check("reload", 4'b1111, exp);
  endtask

  task automatic test_max_neg();
    logic signed [B-1:0] a [64];
    logic signed [OW-1:0] exp [8];
    bit ok;
    for (int i = 0; i < 64; i++) a[i] = -16'sd32768;
    for (int i = 0; i < 8; i++) exp[i] = 35'sd8589934592;
    load(1'b1, a, 64, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL maxneg_load_a: load stalled, required 64 words accepted");
    else n_pass++;
    load(1'b0, a, 8, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL maxneg_load_x: load stalled, required 8 words accepted");
    else n_pass++;
    compute_and_check("maxneg", 4'b1111, exp);
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy1, busy4} !== 2'b11) $display("FAIL midcalc_busy: busy=%b, required 11", {busy1, busy4});
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy1, done1, err1, bus1.in_ready, bus1.out_valid,
         busy4, done4, err4, bus4.in_ready, bus4.out_valid} !== 10'b0 ||
        bus1.data_out !== '0 || bus4.data_out !== '0)
      $display("FAIL midcalc_reset: flags=%b, required all 0",
               {busy1, done1, err1, bus1.in_ready, bus1.out_valid,
                busy4, done4, err4, bus4.in_ready, bus4.out_valid});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({err1, err4, busy1, busy4} !== 4'b1100)
      $display("FAIL midcalc_restart_err: err/busy=%b, required 1100", {err1, err4, busy1, busy4});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_no_load();
    test_identity();
    test_stall();
    test_reload_x();
    test_max_neg();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
